// File: rtl/adder_pkg.sv
// Shared definitions for the nibble-serial adder: FSM encodings and nibble width.
package adder_pkg;

    localparam int NIBBLE_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        ADD  = 2'b01,
        DONE = 2'b10
    } state_t;

endpackage

// File: rtl/serial_adder_seq_if.sv
// Request/result bundle between a requester and serial_adder_seq.
interface serial_adder_seq_if #(
    parameter int WIDTH = 16
);

    logic             start;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             Cin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             Cout;
    logic             overflow;

    modport master (
        output start, A, B, Cin,
        input  busy, done, sum, Cout, overflow
    );

    modport slave (
        input  start, A, B, Cin,
        output busy, done, sum, Cout, overflow
    );

endinterface

// File: rtl/carry_select_adder4bit.sv
// 4-bit carry-select adder: low pair ripples, high pair is precomputed for both
// carries and selected by the low pair's carry-out.
module carry_select_adder4bit (
    input  logic [3:0] A,
    input  logic [3:0] B,
    input  logic       Cin,
    output logic [3:0] sum,
    output logic       Cout
);

    logic [2:0] lo;
    logic [2:0] hi0;
    logic [2:0] hi1;

    assign lo  = {1'b0, A[1:0]} + {1'b0, B[1:0]} + {2'b00, Cin};
    assign hi0 = {1'b0, A[3:2]} + {1'b0, B[3:2]};
    assign hi1 = {1'b0, A[3:2]} + {1'b0, B[3:2]} + 3'd1;

    assign sum[1:0]          = lo[1:0];
    assign {Cout, sum[3:2]}  = lo[2] ? hi1 : hi0;

endmodule

// File: rtl/serial_adder_seq.sv
// Sequences a WIDTH-bit addition through one 4-bit carry-select slice, one
// nibble per clock, LSB nibble first; result shifts into sum from the top.
module serial_adder_seq
    import adder_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic               clk,
    input  logic               rst,
    serial_adder_seq_if.slave  bus
);

    localparam int NIB = WIDTH / NIBBLE_W;
    localparam int CW  = (NIB > 1) ? $clog2(NIB) : 1;
    localparam logic [CW-1:0] LAST = CW'(NIB - 1);

    state_t               state;
    state_t               state_next;
    logic [WIDTH-1:0]     op_a;
    logic [WIDTH-1:0]     op_b;
    logic                 carry_q;
    logic                 sign_a;
    logic                 sign_b;
    logic [CW-1:0]        cnt;
    logic [WIDTH-1:0]     sum_q;
    logic                 cout_q;
    logic                 ovf_q;
    logic [NIBBLE_W-1:0]  slice_sum;
    logic                 slice_cout;
    logic                 accept;
    logic                 last_step;

    carry_select_adder4bit u_slice (
        .A    (op_a[NIBBLE_W-1:0]),
        .B    (op_b[NIBBLE_W-1:0]),
        .Cin  (carry_q),
        .sum  (slice_sum),
        .Cout (slice_cout)
    );

    // Requests are only taken when not busy; DONE accepting gives back-to-back runs.
    assign accept    = bus.start && (state != ADD);
    assign last_step = (state == ADD) && (cnt == LAST);

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (bus.start) state_next = ADD;
            ADD:     if (cnt == LAST) state_next = DONE;
            DONE:    state_next = bus.start ? ADD : IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_a    <= '0;
            op_b    <= '0;
            carry_q <= 1'b0;
            sign_a  <= 1'b0;
            sign_b  <= 1'b0;
            cnt     <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else if (accept) begin
            op_a    <= bus.A;
            op_b    <= bus.B;
            carry_q <= bus.Cin;
            sign_a  <= bus.A[WIDTH-1];
            sign_b  <= bus.B[WIDTH-1];
            cnt     <= '0;
        end else if (state == ADD) begin
            sum_q   <= {slice_sum, sum_q[WIDTH-1:NIBBLE_W]};
            op_a    <= op_a >> NIBBLE_W;
            op_b    <= op_b >> NIBBLE_W;
            carry_q <= slice_cout;
            cnt     <= cnt + 1'b1;
            // The final slice nibble becomes the result MSB nibble.
            if (last_step) begin
                cout_q <= slice_cout;
                ovf_q  <= (sign_a == sign_b) && (slice_sum[NIBBLE_W-1] != sign_a);
            end
        end
    end

    assign bus.busy     = (state == ADD);
    assign bus.done     = (state == DONE);
    assign bus.sum      = sum_q;
    assign bus.Cout     = cout_q;
    assign bus.overflow = ovf_q;

endmodule

// File: tb/tb_serial_adder_seq.sv
// Directed-vector bench for serial_adder_seq (WIDTH=16) with hand-computed results.
module tb_serial_adder_seq;

    logic clk;
    logic rst;
    int   checks;
    int   fails;

    serial_adder_seq_if #(.WIDTH(16)) bus ();

    serial_adder_seq #(.WIDTH(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            fails++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Called at a negedge: presents a request for the next rising edge.
    task automatic applyStimulus(input logic [15:0] a, input logic [15:0] b, input logic cin);
        bus.A     = a;
        bus.B     = b;
        bus.Cin   = cin;
        bus.start = 1'b1;
    endtask

    // Issues a request and counts rising edges (acceptance edge included) until done.
    task automatic runOp(input logic [15:0] a, input logic [15:0] b, input logic cin,
                         input bit keepStart, output int cycles);
        applyStimulus(a, b, cin);
        @(posedge clk);
        cycles = 1;
        @(negedge clk);
        if (!keepStart) bus.start = 1'b0;
        checkOutput("busy_after_accept", 32'(bus.busy), 32'd1);
        while (!bus.done && cycles < 20) begin
            @(posedge clk);
            cycles++;
            @(negedge clk);
        end
        checkOutput("done_seen", 32'(bus.done), 32'd1);
        checkOutput("busy_in_done", 32'(bus.busy), 32'd0);
    endtask

    task automatic checkResult(input string tag, input logic [15:0] s, input logic c, input logic v);
        checkOutput({tag, "_sum"}, 32'(bus.sum), 32'(s));
        checkOutput({tag, "_cout"}, 32'(bus.Cout), 32'(c));
        checkOutput({tag, "_ovf"}, 32'(bus.overflow), 32'(v));
    endtask

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        cin;
        logic [15:0] s;
        logic        c;
        logic        v;
    } vec_t;

    vec_t vecs[4] = '{
        '{16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0},
        '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0},
        '{16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1},
        '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1}
    };

    initial begin
        int  cyc;
        bit  doneSeen;
        checks    = 0;
        fails     = 0;
        rst       = 1'b1;
        bus.start = 1'b0;
        bus.A     = '0;
        bus.B     = '0;
        bus.Cin   = 1'b0;
        repeat (2) @(negedge clk);
        checkOutput("rst_busy", 32'(bus.busy), 32'd0);
        checkOutput("rst_done", 32'(bus.done), 32'd0);
        checkResult("rst", 16'h0000, 1'b0, 1'b0);
        rst = 1'b0;
        @(negedge clk);

        // Plain vectors, including full carry ripple and both overflow signs.
        foreach (vecs[i]) begin
            runOp(vecs[i].a, vecs[i].b, vecs[i].cin, 1'b0, cyc);
            checkOutput($sformatf("v%0d_latency", i), 32'(cyc), 32'd5);
            checkResult($sformatf("v%0d", i), vecs[i].s, vecs[i].c, vecs[i].v);
            @(negedge clk);
            checkOutput($sformatf("v%0d_done_pulse", i), 32'(bus.done), 32'd0);
            checkOutput($sformatf("v%0d_sum_held", i), 32'(bus.sum), 32'(vecs[i].s));
        end

        // Start re-asserted on busy cycles 2..4 with other operands must be ignored.
        applyStimulus(16'h0000, 16'hFFFF, 1'b1);
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        @(posedge clk);
        @(negedge clk);
        applyStimulus(16'h1111, 16'h1111, 1'b0);
        repeat (2) begin
            @(posedge clk);
            @(negedge clk);
        end
        checkOutput("ign_busy_c4", 32'(bus.busy), 32'd1);
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        checkOutput("ign_done", 32'(bus.done), 32'd1);
        checkResult("ign", 16'h0000, 1'b1, 1'b0);
        @(negedge clk);
        checkOutput("ign_idle_done", 32'(bus.done), 32'd0);
        checkOutput("ign_idle_busy", 32'(bus.busy), 32'd0);
        checkOutput("ign_sum_held", 32'(bus.sum), 32'h0000);

        // Back-to-back: start held through the done cycle with new operands.
        runOp(16'h0001, 16'h0002, 1'b0, 1'b1, cyc);
        checkOutput("b2b1_latency", 32'(cyc), 32'd5);
        checkResult("b2b1", 16'h0003, 1'b0, 1'b0);
        runOp(16'h00FF, 16'h0F01, 1'b0, 1'b0, cyc);
        checkOutput("b2b2_latency", 32'(cyc), 32'd5);
        checkResult("b2b2", 16'h1000, 1'b0, 1'b0);
        @(negedge clk);

        // Reset during the second nibble step clears outputs at once and kills the run.
        applyStimulus(16'h1234, 16'h4321, 1'b0);
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        checkOutput("midrst_busy", 32'(bus.busy), 32'd0);
        checkOutput("midrst_done", 32'(bus.done), 32'd0);
        checkResult("midrst", 16'h0000, 1'b0, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        doneSeen = 1'b0;
        repeat (8) begin
            @(negedge clk);
            if (bus.done) doneSeen = 1'b1;
        end
        checkOutput("midrst_no_done", 32'(doneSeen), 32'd0);
        runOp(16'h0F0F, 16'h0101, 1'b0, 1'b0, cyc);
        checkOutput("post_rst_latency", 32'(cyc), 32'd5);
        checkResult("post_rst", 16'h1010, 1'b0, 1'b0);
        @(negedge clk);

        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

endmodule

// File: doc/serial_adder_seq.md
# serial_adder_seq

Nibble-serial multi-word adder that sits directly upstream of the 4-bit carry-select adder slice. It sequences a wide addition through that slice one nibble per clock. It latches two WIDTH-bit operands on a start request and presents one nibble pair plus the running carry to the slice each cycle. It collects the slice's 4-bit sum and carry-out into a result register, then signals completion with a one-cycle done pulse.

## Interface
- WIDTH, default 16: operand width in bits. Must be a multiple of 4 and at least 8.
- NIB, default WIDTH/4: derived number of nibble steps. Not overridable.
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  request; sampled only when busy=0.
- A  in  WIDTH  operand A; sampled with start.
- B  in  WIDTH  operand B; sampled with start.
- Cin  in  1  carry-in to nibble 0; sampled with start.
- busy  out  1  high while nibbles are being processed.
- done  out  1  one-cycle pulse; result valid.
- sum  out  WIDTH  result; held until the next accepted start.
- Cout  out  1  carry out of the MSB nibble.
- overflow  out  1  two's-complement overflow of A+B+Cin.

## Operation
- The FSM has three states: IDLE, ADD, DONE.
- Accepting a request:
  - start=1 is accepted when busy=0, i.e. in IDLE or DONE.
  - On acceptance: A and B load into the operand shift registers; the carry register loads Cin; the sign bits A[WIDTH-1] and B[WIDTH-1] are latched; the nibble counter clears; state goes to ADD.
  - sum, Cout and overflow are not cleared at acceptance.
- ADD, one step per cycle:
  - Drive the slice with operand-A bits [3:0], operand-B bits [3:0] and the carry register.
  - Shift the slice's 4-bit sum into sum from the MSB end (sum <= {slice_sum, sum[WIDTH-1:4]}).
  - Shift both operand registers right by 4.
  - Load the carry register with the slice's carry-out.
  - Increment the counter.
- ADD to DONE: when the counter equals NIB-1, the final step completes and state goes to DONE.
  - On that edge, Cout <= slice carry-out.
  - overflow <= (latched sign of A == latched sign of B) && (final sum MSB != latched sign of A).
- DONE: done=1 and busy=0.
  - With start=1, go to ADD (back-to-back operation).
  - Otherwise go to IDLE.
- start while busy=1 is ignored: no queueing, no error flag.
- busy is 1 exactly in ADD.
- done is 1 exactly in DONE.
- All arithmetic is modulo 2^WIDTH. The carry out of the MSB nibble appears only on Cout.
- Reset, asynchronous, at any time including mid-ADD:
  - state=IDLE, busy=0, done=0.
  - sum=0, Cout=0, overflow=0.
  - Operand registers, carry register and counter are cleared.
  - An aborted operation never produces done.

## Timing
- start sampled high at edge E0 → ADD during cycles E0..E0+NIB-1 → done high for exactly the cycle after edge E0+NIB. Latency is NIB+1 clocks (5 for WIDTH=16).
- sum, Cout and overflow are registered. They are valid from the done cycle until the edge that accepts the next start.
- Back-to-back throughput: one result per NIB+1 cycles.
- The slice path is purely combinational within one cycle. The critical path is 4-bit adder plus mux, independent of WIDTH.

## Structure
- A shared package/header `adder_pkg` holds:
  - state encodings: IDLE=2'b00, ADD=2'b01, DONE=2'b10;
  - NIBBLE_W=4.
- One sub-module instance: the existing `carry_select_adder4bit` (A, B, Cin → sum, Cout) performs each nibble add.
- No other hierarchy. The FSM, counter ($clog2(NIB) bits) and shift registers stay in this module.

## Test plan
- A=0x1234, B=0x4321, Cin=0 → sum=0x5555, Cout=0, overflow=0; done exactly 5 cycles after start, for one cycle.
- A=0xFFFF, B=0x0001, Cin=0 → sum=0x0000, Cout=1, overflow=0. This checks carry ripples across all four nibble steps.
- A=0x7FFF, B=0x0001 → sum=0x8000, Cout=0, overflow=1. A=0x8000, B=0x8000 → sum=0x0000, Cout=1, overflow=1.
- Ignored start: A=0x0000, B=0xFFFF, Cin=1 → sum=0x0000, Cout=1. Assert start again with different operands on cycles 2–4 of busy → ignored, result unchanged.
- Back-to-back: hold start=1 through the done cycle with new operands 0x00FF+0x0F01 → the second done arrives 5 cycles after the first, sum=0x1000.
- Reset mid-operation: assert rst during ADD step 2 → outputs zero immediately, no done pulse. A new start after release completes normally.
